// File: rtl/gcd_pkg.sv
// Shared definitions for the gcd scheduler: state encoding and default sizes.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package gcd_pkg;

    // Default operand/result width; must match the attached gcd core.
    localparam int GCD_WIDTH = 8;

    // Core latency, start edge to done, for a == b or a zero operand.
    localparam int GCD_DONE_LAT = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority picker: first set req bit at or above ptr, wrapping to 0.
// Latency: combinational.
// Backpressure: none; grant is all-zero when req is all-zero.
//
// Ports:
//   req   - request vector
//   ptr   - index with highest priority this round
//   grant - one-hot selected requester
//   idx   - binary index of the selected requester
module rr_pick #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         grant,
    output logic [$clog2(NREQ)-1:0] idx
);

    localparam int IW = $clog2(NREQ);

    logic [NREQ-1:0] hi;
    logic [NREQ-1:0] sel;

    always_comb begin
        hi = '0;
        for (int j = 0; j < NREQ; j++) begin
            hi[j] = req[j] && (IW'(j) >= ptr);
        end
        // Requests at or above ptr win; otherwise wrap and take the lowest.
        sel   = (hi != '0) ? hi : req;
        grant = '0;
        idx   = '0;
        // Descending scan so the lowest set bit is the one that sticks.
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (sel[j]) begin
                grant    = '0;
                grant[j] = 1'b1;
                idx      = IW'(j);
            end
        end
    end

endmodule

// File: rtl/gcd_sched.sv
// Round-robin scheduler sharing one external gcd core among NREQ requesters.
// Latency: grant 1 cycle after req seen in IDLE; response 1 cycle after gcd_done.
// Backpressure: requesters hold req/operands until gnt; one job in flight at a time.
//
// Ports:
//   clock, reset_n         - clock, async active-low reset
//   req, a_in, b_in        - per-requester request and packed operands
//   gnt, rsp_valid         - one-hot pulses: operands accepted / result valid
//   rsp_data, rsp_cycles   - last result and its core cycle count (held)
//   busy                   - high whenever not IDLE
//   gcd_start, gcd_a/b     - command to the core
//   gcd_outp, gcd_done     - result and done pulse from the core
module gcd_sched
    import gcd_pkg::*;
#(
    parameter int WIDTH  = GCD_WIDTH,
    parameter int NREQ   = 4,
    parameter int CWIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*WIDTH-1:0]  a_in,
    input  logic [NREQ*WIDTH-1:0]  b_in,
    output logic [NREQ-1:0]        gnt,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [WIDTH-1:0]       rsp_data,
    output logic [CWIDTH-1:0]      rsp_cycles,
    output logic                   busy,
    output logic                   gcd_start,
    output logic [WIDTH-1:0]       gcd_a,
    output logic [WIDTH-1:0]       gcd_b,
    input  logic [WIDTH-1:0]       gcd_outp,
    input  logic                   gcd_done
);

    localparam int IW = $clog2(NREQ);

    state_t            state, state_nxt;
    logic [IW-1:0]     ptr;
    logic [IW-1:0]     owner;
    logic [WIDTH-1:0]  op_a, op_b;
    logic [CWIDTH-1:0] cnt;

    logic [NREQ-1:0]   pick_gnt;
    logic [IW-1:0]     pick_idx;
    logic [WIDTH-1:0]  pick_a, pick_b;
    logic [NREQ-1:0]   owner_oh;
    logic [IW-1:0]     ptr_nxt;
    logic [CWIDTH-1:0] cnt_inc;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req   (req),
        .ptr   (ptr),
        .grant (pick_gnt),
        .idx   (pick_idx)
    );

    // Operand slice of the picked requester, and owner as a one-hot vector.
    always_comb begin
        pick_a   = '0;
        pick_b   = '0;
        owner_oh = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_idx == IW'(i)) begin
                pick_a = a_in[i*WIDTH +: WIDTH];
                pick_b = b_in[i*WIDTH +: WIDTH];
            end
            owner_oh[i] = (owner == IW'(i));
        end
    end

    // Priority moves past the requester just served so it cannot starve others.
    assign ptr_nxt = (owner == IW'(NREQ - 1)) ? '0 : owner + IW'(1);
    assign cnt_inc = (cnt == {CWIDTH{1'b1}}) ? cnt : cnt + CWIDTH'(1);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (req != '0) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT:  if (gcd_done) state_nxt = S_RESP;
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            ptr        <= '0;
            owner      <= '0;
            op_a       <= '0;
            op_b       <= '0;
            cnt        <= '0;
            gnt        <= '0;
            rsp_valid  <= '0;
            gcd_start  <= 1'b0;
            busy       <= 1'b0;
            rsp_data   <= '0;
            rsp_cycles <= '0;
        end else begin
            state     <= state_nxt;
            busy      <= (state_nxt != S_IDLE);
            gnt       <= '0;
            gcd_start <= 1'b0;
            rsp_valid <= '0;
            case (state)
                S_IDLE: begin
                    if (req != '0) begin
                        op_a      <= pick_a;
                        op_b      <= pick_b;
                        owner     <= pick_idx;
                        gnt       <= pick_gnt;
                        gcd_start <= 1'b1;
                        cnt       <= '0;
                    end
                end
                S_WAIT: begin
                    // The done cycle itself counts, hence cnt+1 at capture.
                    if (gcd_done) begin
                        rsp_data   <= gcd_outp;
                        rsp_cycles <= cnt_inc;
                        rsp_valid  <= owner_oh;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                S_RESP:  ptr <= ptr_nxt;
                default: ;
            endcase
        end
    end

    assign gcd_a = op_a;
    assign gcd_b = op_b;

endmodule

// File: tb/tb_gcd_sched.sv
// Self-checking bench for gcd_sched with a behavioural gcd core and job scoreboard.
// Latency: n/a.
// Backpressure: requester model holds req and operands until its gnt is seen.
module tb_gcd_sched;
    import gcd_pkg::*;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;

    logic                  clock   = 1'b0;
    logic                  reset_n = 1'b0;
    logic [NREQ-1:0]       req     = '0;
    logic [NREQ*WIDTH-1:0] a_in    = '0;
    logic [NREQ*WIDTH-1:0] b_in    = '0;
    logic [WIDTH-1:0]      gcd_outp = '0;
    logic                  gcd_done = 1'b0;

    logic [NREQ-1:0]  gnt, rsp_valid;
    logic [WIDTH-1:0] rsp_data, gcd_a, gcd_b;
    logic [15:0]      rsp_cycles;
    logic             busy, gcd_start;

    logic [NREQ-1:0]  gnt_4, rsp_valid_4;
    logic [WIDTH-1:0] rsp_data_4, gcd_a_4, gcd_b_4;
    logic [3:0]       rsp_cycles_4;
    logic             busy_4, gcd_start_4;

    always #5 clock = ~clock;

    gcd_sched #(.WIDTH(WIDTH), .NREQ(NREQ), .CWIDTH(16)) dut (
        .clock(clock), .reset_n(reset_n), .req(req), .a_in(a_in), .b_in(b_in),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_cycles(rsp_cycles),
        .busy(busy), .gcd_start(gcd_start), .gcd_a(gcd_a), .gcd_b(gcd_b),
        .gcd_outp(gcd_outp), .gcd_done(gcd_done)
    );

    // Narrow-counter copy running in lockstep, used for saturation checks.
    gcd_sched #(.WIDTH(WIDTH), .NREQ(NREQ), .CWIDTH(4)) dut4 (
        .clock(clock), .reset_n(reset_n), .req(req), .a_in(a_in), .b_in(b_in),
        .gnt(gnt_4), .rsp_valid(rsp_valid_4), .rsp_data(rsp_data_4), .rsp_cycles(rsp_cycles_4),
        .busy(busy_4), .gcd_start(gcd_start_4), .gcd_a(gcd_a_4), .gcd_b(gcd_b_4),
        .gcd_outp(gcd_outp), .gcd_done(gcd_done)
    );

    typedef struct { int idx; int a; int b; } job_t;
    typedef struct { int idx; int a; int b; int ca; int cb; } grant_t;
    typedef struct { int idx; int data; int cyc; int cyc4; } rsp_t;

    job_t   pend[$];
    grant_t glog[$];
    rsp_t   rlog[$];
    int     exp_order[$];

    int n_asrt = 0;
    int n_fail = 0;
    int core_rem = 0;
    int bad_onehot = 0;
    int max_wait = 0;
    int waits[NREQ];
    bit stray = 1'b0;

    // Reference gcd; the core returns 0 whenever either operand is 0.
    function automatic int ref_gcd(input int a, input int b);
        int t;
        if (a <= 0 || b <= 0) return 0;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Core latency: base latency plus one cycle per subtraction step.
    function automatic int core_lat(input int a, input int b);
        int n = 0;
        if (a < 0 || b < 0) return 0;
        if (a == 0 || b == 0) return GCD_DONE_LAT;
        while (a != b) begin
            if (a > b) a = a - b;
            else       b = b - a;
            n++;
        end
        return GCD_DONE_LAT + n;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_asrt++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic add_job(input int idx, input int a, input int b);
        pend.push_back('{idx, a, b});
    endtask

    // One cycle: core model, grant/response monitor, requester drive.
    task automatic tick();
        int pos;
        @(negedge clock);
        gcd_done = 1'b0;
        if (!reset_n) begin
            core_rem = 0;
        end else if (core_rem > 0) begin
            core_rem--;
            if (core_rem == 0) gcd_done = 1'b1;
        end else if (gcd_start) begin
            core_rem = core_lat(int'(gcd_a), int'(gcd_b));
            gcd_outp = WIDTH'(ref_gcd(int'(gcd_a), int'(gcd_b)));
        end
        if (stray) gcd_done = 1'b1;

        if (gnt != '0) begin
            if ($countones(gnt) != 1) bad_onehot++;
            for (int i = 0; i < NREQ; i++) begin
                if (gnt[i]) begin
                    pos = -1;
                    foreach (pend[k]) if (pos < 0 && pend[k].idx == i) pos = k;
                    for (int j = 0; j < NREQ; j++) if (j != i && req[j]) waits[j]++;
                    if (waits[i] > max_wait) max_wait = waits[i];
                    waits[i] = 0;
                    if (pos >= 0) begin
                        glog.push_back('{i, pend[pos].a, pend[pos].b, int'(gcd_a), int'(gcd_b)});
                        pend.delete(pos);
                    end else begin
                        glog.push_back('{i, -1, -1, int'(gcd_a), int'(gcd_b)});
                    end
                end
            end
        end
        if (rsp_valid != '0) begin
            if ($countones(rsp_valid) != 1) bad_onehot++;
            pos = 0;
            for (int i = NREQ - 1; i >= 0; i--) if (rsp_valid[i]) pos = i;
            rlog.push_back('{pos, int'(rsp_data), int'(rsp_cycles), int'(rsp_cycles_4)});
        end

        req = '0;
        for (int i = 0; i < NREQ; i++) begin
            pos = -1;
            foreach (pend[k]) if (pos < 0 && pend[k].idx == i) pos = k;
            if (pos >= 0) begin
                req[i] = 1'b1;
                a_in[i*WIDTH +: WIDTH] = WIDTH'(pend[pos].a);
                b_in[i*WIDTH +: WIDTH] = WIDTH'(pend[pos].b);
            end
        end
    endtask

    task automatic run(input int budget);
        int n = 0;
        do begin
            tick();
            n++;
        end while ((pend.size() != 0 || busy) && n < budget);
        chk("run_within_budget", int'(n < budget), 1);
    endtask

    task automatic check_log();
        grant_t g;
        rsp_t   r;
        int     lat;
        chk("rsp_count", rlog.size(), glog.size());
        while (glog.size() > 0 && rlog.size() > 0) begin
            g = glog.pop_front();
            r = rlog.pop_front();
            if (exp_order.size() > 0) chk("grant_order", g.idx, exp_order.pop_front());
            chk("rsp_owner", r.idx, g.idx);
            chk("core_a", g.ca, g.a);
            chk("core_b", g.cb, g.b);
            chk("rsp_data", r.data, ref_gcd(g.a, g.b));
            lat = core_lat(g.a, g.b);
            chk("rsp_cycles", r.cyc, (lat > 65535) ? 65535 : lat);
            chk("rsp_cycles_sat", r.cyc4, (lat > 15) ? 15 : lat);
        end
        chk("grant_order_consumed", exp_order.size(), 0);
        glog.delete();
        rlog.delete();
        exp_order.delete();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_gnt"},        int'(gnt), 0);
        chk({tag, "_rsp_valid"},  int'(rsp_valid), 0);
        chk({tag, "_busy"},       int'(busy), 0);
        chk({tag, "_gcd_start"},  int'(gcd_start), 0);
        chk({tag, "_rsp_data"},   int'(rsp_data), 0);
        chk({tag, "_rsp_cycles"}, int'(rsp_cycles), 0);
        chk({tag, "_gcd_a"},      int'(gcd_a), 0);
        chk({tag, "_gcd_b"},      int'(gcd_b), 0);
    endtask

    initial begin
        int nj, ra, rb;
        for (int i = 0; i < NREQ; i++) waits[i] = 0;

        // Reset values
        reset_n = 1'b0;
        repeat (3) tick();
        #1;
        chk_zero("reset");
        reset_n = 1'b1;
        tick();

        // Single job on requester 0
        add_job(0, 12, 18);
        exp_order = '{0};
        run(2000);
        check_log();
        chk("single_rsp_data", int'(rsp_data), 6);
        chk("single_busy_low", int'(busy), 0);

        // Zero operand on requester 2
        add_job(2, 0, 9);
        exp_order = '{2};
        run(2000);
        chk("zero_rsp_data", int'(rsp_data), 0);
        chk("zero_rsp_cycles", int'(rsp_cycles), 3);
        check_log();

        // Serve requester 3 so the pointer wraps back to 0
        add_job(3, 15, 5);
        exp_order = '{3};
        run(2000);
        check_log();

        // All four at once, then 0 and 3 together
        add_job(0, 8, 12);
        add_job(1, 9, 6);
        add_job(2, 7, 7);
        add_job(3, 15, 25);
        exp_order = '{0, 1, 2, 3};
        run(2000);
        check_log();
        add_job(3, 21, 14);
        add_job(0, 9, 3);
        exp_order = '{0, 3};
        run(2000);
        check_log();

        // Requester 1 holds req continuously against requester 3
        add_job(1, 4, 6);
        add_job(1, 5, 10);
        add_job(1, 9, 12);
        add_job(3, 8, 8);
        add_job(3, 14, 21);
        exp_order = '{1, 3, 1, 3, 1};
        run(3000);
        check_log();

        // Reset while a long job is in WAIT
        add_job(0, 200, 1);
        repeat (20) tick();
        chk("midjob_busy", int'(busy), 1);
        reset_n = 1'b0;
        #1;
        chk_zero("midjob_reset");
        tick();
        reset_n = 1'b1;
        chk("midjob_no_rsp_before", rlog.size(), 0);
        glog.delete();
        pend.delete();
        for (int i = 0; i < NREQ; i++) waits[i] = 0;
        repeat (250) tick();
        chk("midjob_no_rsp_after", rlog.size(), 0);
        chk("midjob_idle", int'(busy), 0);
        add_job(0, 10, 4);
        exp_order = '{0};
        run(2000);
        check_log();
        chk("after_reset_rsp_data", int'(rsp_data), 2);

        // Stray done while idle
        stray = 1'b1;
        tick();
        stray = 1'b0;
        repeat (5) tick();
        chk("stray_no_rsp", rlog.size(), 0);
        chk("stray_no_gnt", glog.size(), 0);
        chk("stray_idle", int'(busy), 0);

        // Long job: cycle count and 4-bit saturation
        add_job(1, 255, 1);
        exp_order = '{1};
        run(3000);
        chk("long_rsp_cycles", int'(rsp_cycles), 257);
        chk("long_rsp_cycles_sat", int'(rsp_cycles_4), 15);
        chk("long_rsp_data", int'(rsp_data), 1);
        check_log();

        // Random bursts
        for (int r = 0; r < 12; r++) begin
            nj = $urandom_range(1, 6);
            for (int k = 0; k < nj; k++) begin
                ra = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 63);
                rb = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 63);
                add_job($urandom_range(0, NREQ - 1), ra, rb);
            end
            run(6000);
            check_log();
        end

        chk("fairness_bound", int'(max_wait <= NREQ - 1), 1);
        chk("onehot_violations", bad_onehot, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
